// File: rtl/pipe_stage_hs_pkg.sv
// Shared types and constants for the handshaked inter-stage pipeline registers.
package pipe_stage_hs_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } pipe_ctrl_t;

    localparam int unsigned PIPE_CTRL_W = $bits(pipe_ctrl_t);
    localparam pipe_ctrl_t  CTRL_NOP    = '0;

    // Data bundle widths per pipeline boundary
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_DATA_W  = 32;
    localparam int unsigned EX_MEM_DATA_W = 32;
    localparam int unsigned MEM_WB_DATA_W = 32;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single holding register: valid flag, control bundle and data bundle with load/clear.
module pipe_skid_slot #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clearing zeroes ctrl so an empty slot always reads as a NOP; data may go stale
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with optional 2-entry skid buffer and synchronous flush.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SKID_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    occ_e occ_q, occ_d;
    logic in_ready_q, in_ready_d;
    logic pop, accept, in_ready;
    logic main_load, main_clear, main_from_skid;
    logic skid_load, skid_clear;
    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready = (SKID_EN != 0) ? in_ready_q : (~main_valid | out_ready_i);
    assign pop      = main_valid & out_ready_i;
    assign accept   = in_valid_i & in_ready & ~flush_i;

    always_comb begin
        occ_d          = occ_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush_i) begin
            occ_d      = StEmpty;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (occ_q)
                StEmpty: begin
                    if (accept) begin
                        occ_d     = StOne;
                        main_load = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        // Without a skid, in_ready already implies pop here
                        if (SKID_EN != 0) begin
                            occ_d     = StFull;
                            skid_load = 1'b1;
                        end
                    end else if (pop) begin
                        occ_d      = StEmpty;
                        main_clear = 1'b1;
                    end
                end
                StFull: begin
                    if (pop && skid_valid) begin
                        occ_d          = StOne;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    occ_d      = StEmpty;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
        in_ready_d = (occ_d != StFull);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q      <= StEmpty;
            in_ready_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (main_load),
        .clear_i (main_clear),
        .ctrl_i  (main_from_skid ? skid_ctrl : in_ctrl_i),
        .data_i  (main_from_skid ? skid_data : in_data_i),
        .valid_o (main_valid),
        .ctrl_o  (out_ctrl_o),
        .data_o  (out_data_o)
    );

    if (SKID_EN != 0) begin : g_skid
        pipe_skid_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_skid (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .ctrl_i  (in_ctrl_i),
            .data_i  (in_data_i),
            .valid_o (skid_valid),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
        );
    end else begin : g_no_skid
        assign skid_valid = 1'b0;
        assign skid_ctrl  = '0;
        assign skid_data  = '0;
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = main_valid;
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed checks of the skid variant plus a randomized scoreboard run of the single-entry variant.
module tb_pipe_stage_hs;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // SKID_EN=1 instance
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [31:0] in_data, out_data;
    logic [1:0]  occ;

    // SKID_EN=0 instance
    logic        r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [7:0]  r_in_ctrl, r_out_ctrl;
    logic [31:0] r_in_data, r_out_data;
    logic [1:0]  r_occ;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_hs #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl),
        .out_data_o(out_data), .occupancy_o(occ)
    );

    pipe_stage_hs #(.DATA_W(32), .CTRL_W(8), .SKID_EN(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(r_flush),
        .in_valid_i(r_in_valid), .in_ready_o(r_in_ready), .in_ctrl_i(r_in_ctrl),
        .in_data_i(r_in_data), .out_valid_o(r_out_valid), .out_ready_i(r_out_ready),
        .out_ctrl_o(r_out_ctrl), .out_data_o(r_out_data), .occupancy_o(r_occ)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [31:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    logic [39:0] sb[$];
    logic [39:0] exp_e;
    logic        hold, prev_stall;
    logic [7:0]  prev_ctrl;
    logic [31:0] prev_data, cnt;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        r_flush = 1'b0; r_in_valid = 1'b0; r_in_ctrl = '0; r_in_data = '0; r_out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("rel_in_ready_high", 64'(in_ready), 64'd1);

        // Streaming 1..16 with one cycle latency
        out_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            send(8'(c), 32'(c));
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(c));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", 64'(out_valid), 64'd0);
        check("stream_end_ctrl", 64'(out_ctrl), 64'd0);
        check("stream_end_occ", 64'(occ), 64'd0);

        // Backpressure A,B,C
        out_ready = 1'b0;
        send(8'h01, 32'hA);
        tick();
        check("bp_occ1", 64'(occ), 64'd1);
        send(8'h02, 32'hB);
        tick();
        check("bp_occ2", 64'(occ), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        send(8'h03, 32'hC);
        tick();
        check("bp_occ_hold", 64'(occ), 64'd2);
        check("bp_head", 64'(out_data), 64'hA);
        check("bp_head_ctrl", 64'(out_ctrl), 64'h01);
        out_ready = 1'b1;
        tick();
        check("bp_out_b", 64'(out_data), 64'hB);
        check("bp_out_b_valid", 64'(out_valid), 64'd1);
        check("bp_occ_after_b", 64'(occ), 64'd1);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        tick();
        check("bp_out_c", 64'(out_data), 64'hC);
        check("bp_out_c_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush at occupancy 2 with an incoming entry
        out_ready = 1'b0;
        send(8'h11, 32'hD);
        tick();
        send(8'h12, 32'hE);
        tick();
        check("fl_occ2", 64'(occ), 64'd2);
        send(8'hFF, 32'hF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_occ", 64'(occ), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_emerge", 64'(out_valid), 64'd0);
        end

        // Simultaneous accept and pop at ONE
        out_ready = 1'b0;
        send(8'h03, 32'h55);
        tick();
        check("sim_a", 64'(out_data), 64'h55);
        send(8'h04, 32'h66);
        out_ready = 1'b1;
        tick();
        check("sim_b", 64'(out_data), 64'h66);
        check("sim_b_ctrl", 64'(out_ctrl), 64'h04);
        check("sim_occ", 64'(occ), 64'd1);
        in_valid = 1'b0;
        tick();
        check("sim_empty", 64'(occ), 64'd0);

        // Random traffic on the single-entry variant
        hold = 1'b0; prev_stall = 1'b0; prev_ctrl = '0; prev_data = '0; cnt = 32'd1;
        for (int i = 0; i < 10000; i++) begin
            if (r_out_valid == 1'b0) check("r_bubble_ctrl", 64'(r_out_ctrl), 64'd0);
            if (prev_stall) begin
                check("r_stall_data", 64'(r_out_data), 64'(prev_data));
                check("r_stall_ctrl", 64'(r_out_ctrl), 64'(prev_ctrl));
            end
            if (!hold) begin
                r_in_valid = ($urandom_range(0, 3) != 0);
                r_in_data  = cnt;
                r_in_ctrl  = cnt[7:0] | 8'h01;
            end
            r_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (r_out_valid && r_out_ready) begin
                if (sb.size() == 0) begin
                    check("r_unexpected_pop", 64'd1, 64'd0);
                end else begin
                    exp_e = sb.pop_front();
                    check("r_data", 64'(r_out_data), 64'(exp_e[31:0]));
                    check("r_ctrl", 64'(r_out_ctrl), 64'(exp_e[39:32]));
                end
            end
            if (r_in_valid && r_in_ready) begin
                sb.push_back({r_in_ctrl, r_in_data});
                cnt = cnt + 1;
            end
            hold       = r_in_valid & ~r_in_ready;
            prev_stall = r_out_valid & ~r_out_ready;
            prev_data  = r_out_data;
            prev_ctrl  = r_out_ctrl;
            tick();
            check("r_occ", 64'(r_occ), 64'(sb.size()));
        end
        r_in_valid = 1'b0;
        r_out_ready = 1'b1;
        tick(); tick();
        check("r_drain_valid", 64'(r_out_valid), 64'd0);

        // Reset mid-stream with two entries held
        out_ready = 1'b0;
        send(8'h21, 32'h77);
        tick();
        send(8'h22, 32'h88);
        tick();
        in_valid = 1'b0;
        check("mr_occ2", 64'(occ), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ctrl", 64'(out_ctrl), 64'd0);
        check("mr_occ", 64'(occ), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mr_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("mr_in_ready_high", 64'(in_ready), 64'd1);
        check("mr_still_empty", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
